// File: rtl/mem_pkg.sv
// Shared definitions for the cache-facing line memory: responder FSM states
// and the default line geometry, which must agree with the data cache.
package mem_pkg;

  localparam int DEFAULT_LINE_SIZE = 16;
  localparam int LINE_BITS         = DEFAULT_LINE_SIZE * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/line_mem_array.sv
// Synchronous single-port line array. A write and a read issued in the same
// cycle are ordered write-first, so the read returns the freshly written line.
// Only the read register is reset; the storage keeps whatever it held.
module line_mem_array
  import mem_pkg::*;
#(
  parameter int LINE_W    = LINE_BITS,
  parameter int NUM_LINES = 256,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [NUM_LINES];

  // Storage write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read; forwards the write data so a combined access sees the new line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[idx];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Responder side of the cache<->memory line handshake. Accepts one line
// request while idle, stays busy for DELAY cycles, then commits the write
// and/or returns the line with a single-cycle is_output_valid pulse.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int LINE_SIZE     = DEFAULT_LINE_SIZE,
  parameter int NUM_LINES     = 256,
  parameter int DELAY         = 50,
  parameter int LINE_IDX_SIZE = $clog2(NUM_LINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_SIZE*8-1:0] din,
  output logic                   mem_ready,
  output logic                   is_output_valid,
  output logic [LINE_SIZE*8-1:0] dout
);

  localparam int LINE_W = LINE_SIZE * 8;
  localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  mem_state_t               state;
  logic [CNT_W-1:0]         cnt;
  logic                     rd_q;
  logic                     wr_q;
  logic [LINE_IDX_SIZE-1:0] idx_q;
  logic [LINE_W-1:0]        din_q;

  logic accept;
  logic finish;
  logic unused_addr_bits;

  // Byte offset and bits above the line index are don't-care (index aliases).
  assign unused_addr_bits = ^{addr[31:4+LINE_IDX_SIZE], addr[3:0]};

  assign accept = is_input_valid && (state == ST_IDLE) && (mem_read || mem_write);
  assign finish = (state == ST_BUSY) && (cnt == '0);

  assign mem_ready       = (state == ST_IDLE);
  assign is_output_valid = (state == ST_DONE) && rd_q;

  // Control FSM and latency counter; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(DELAY - 1);
            rd_q  <= mem_read;
            wr_q  <= mem_write;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Request payload capture; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= addr[4 +: LINE_IDX_SIZE];
      din_q <= din;
    end
  end

  line_mem_array #(
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (LINE_IDX_SIZE)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (finish && wr_q && !reset),
    .re    (finish && rd_q && !reset),
    .idx   (idx_q),
    .wdata (din_q),
    .rdata (dout)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a DELAY=4 instance for the main
// scenarios and a DELAY=1 instance for back-to-back throughput.
module tb_line_mem_responder;

  localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LINE_C = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;
  localparam logic [127:0] LINE_D = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] ONES   = {128{1'b1}};

  logic         clk;
  logic         reset;

  logic         valid0, rd0, wr0;
  logic [31:0]  addr0;
  logic [127:0] din0, dout0;
  logic         ready0, ovld0;

  logic         valid1, rd1, wr1;
  logic [31:0]  addr1;
  logic [127:0] din1, dout1;
  logic         ready1, ovld1;

  int checks;
  int failures;

  line_mem_responder #(.LINE_SIZE(16), .NUM_LINES(256), .DELAY(4)) dut (
    .clk(clk), .reset(reset), .is_input_valid(valid0), .addr(addr0),
    .mem_read(rd0), .mem_write(wr0), .din(din0), .mem_ready(ready0),
    .is_output_valid(ovld0), .dout(dout0)
  );

  line_mem_responder #(.LINE_SIZE(16), .NUM_LINES(256), .DELAY(1)) dut1 (
    .clk(clk), .reset(reset), .is_input_valid(valid1), .addr(addr1),
    .mem_read(rd1), .mem_write(wr1), .din(din1), .mem_ready(ready1),
    .is_output_valid(ovld1), .dout(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the DELAY=4 instance for one edge; returns in cycle 1.
  task automatic issue0(input logic r, input logic w, input logic [31:0] a, input logic [127:0] d);
    valid0 = 1'b1; rd0 = r; wr0 = w; addr0 = a; din0 = d;
    tick();
    valid0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
  endtask

  // Wait (bounded) for the read pulse; lat counts cycles since the accept cycle.
  task automatic wait_pulse0(output int lat);
    lat = 1;
    while (!ovld0 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready0); end
    checks++;
    if (ovld0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ovld0); end
    checks++;
    if (dout0 !== 128'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout0); end
    checks++;
    if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (ovld0 === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_write_read();
    int pulses;
    int lat;
    issue0(1'b0, 1'b1, 32'h0000_0120, LINE_A);
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      if (ovld0 === 1'b1) pulses++;
      checks++;
      if (ready0 !== 1'b0) begin failures++; $display("FAIL wr_busy_ready cyc=%0d got=%b exp=0", c, ready0); end
      tick();
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL wr_no_pulse got=%0d exp=0", pulses); end
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL wr_ready_back got=%b exp=1", ready0); end

    issue0(1'b1, 1'b0, 32'h0000_012C, 128'h0);
    wait_pulse0(lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", lat); end
    checks++;
    if (dout0 !== LINE_A) begin failures++; $display("FAIL rd_data got=%h exp=%h", dout0, LINE_A); end
    tick();
    checks++;
    if (ready0 !== 1'b1 || ovld0 !== 1'b0) begin
      failures++; $display("FAIL rd_after got=ready%b/valid%b exp=ready1/valid0", ready0, ovld0);
    end
    checks++;
    if (dout0 !== LINE_A) begin failures++; $display("FAIL dout_hold got=%h exp=%h", dout0, LINE_A); end
  endtask

  task automatic test_busy_block();
    int lat;
    issue0(1'b0, 1'b1, 32'h0000_0240, LINE_B);
    repeat (5) tick();
    issue0(1'b1, 1'b0, 32'h0000_0120, 128'h0);
    // A competing read is held asserted throughout the busy window.
    valid0 = 1'b1; rd0 = 1'b1; addr0 = 32'h0000_0240;
    wait_pulse0(lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL blk_latency got=%0d exp=5", lat); end
    checks++;
    if (dout0 !== LINE_A) begin failures++; $display("FAIL blk_first_data got=%h exp=%h", dout0, LINE_A); end
    tick();
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL blk_ready got=%b exp=1", ready0); end
    tick();
    valid0 = 1'b0; rd0 = 1'b0;
    checks++;
    if (ready0 !== 1'b0) begin failures++; $display("FAIL blk_second_accept got=%b exp=0", ready0); end
    wait_pulse0(lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL blk_second_latency got=%0d exp=5", lat); end
    checks++;
    if (dout0 !== LINE_B) begin failures++; $display("FAIL blk_second_data got=%h exp=%h", dout0, LINE_B); end
    tick();
  endtask

  task automatic test_combined_alias();
    int lat;
    issue0(1'b1, 1'b1, 32'h0000_0120, ONES);
    wait_pulse0(lat);
    checks++;
    if (lat !== 5 || dout0 !== ONES) begin
      failures++; $display("FAIL combined got=%h lat=%0d exp=%h lat=5", dout0, lat, ONES);
    end
    tick();
    issue0(1'b0, 1'b1, 32'h0000_1120, LINE_C);
    repeat (5) tick();
    issue0(1'b1, 1'b0, 32'h0000_0120, 128'h0);
    wait_pulse0(lat);
    checks++;
    if (dout0 !== LINE_C) begin failures++; $display("FAIL alias got=%h exp=%h", dout0, LINE_C); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    int lat;
    issue0(1'b0, 1'b1, 32'h0000_0120, LINE_D);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready0 !== 1'b1 || ovld0 !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=ready%b/valid%b exp=ready1/valid0", ready0, ovld0);
    end
    checks++;
    if (dout0 !== 128'h0) begin failures++; $display("FAIL midrst_dout got=%h exp=0", dout0); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (ovld0 === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
    issue0(1'b1, 1'b0, 32'h0000_0120, 128'h0);
    wait_pulse0(lat);
    checks++;
    if (dout0 !== LINE_C) begin failures++; $display("FAIL midrst_keep got=%h exp=%h", dout0, LINE_C); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0]  addrs [3];
    logic [127:0] lines [3];
    addrs[0] = 32'h0000_0010; lines[0] = LINE_A;
    addrs[1] = 32'h0000_0020; lines[1] = LINE_B;
    addrs[2] = 32'h0000_0030; lines[2] = LINE_D;
    for (int k = 0; k < 3; k++) begin
      valid1 = 1'b1; rd1 = 1'b0; wr1 = 1'b1; addr1 = addrs[k]; din1 = lines[k];
      tick();
      valid1 = 1'b0; wr1 = 1'b0;
      tick();
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      valid1 = 1'b1; rd1 = 1'b1; addr1 = addrs[k];
      tick();
      checks++;
      if (ready1 !== 1'b0 || ovld1 !== 1'b0) begin
        failures++; $display("FAIL b2b_busy k=%0d got=ready%b/valid%b exp=ready0/valid0", k, ready1, ovld1);
      end
      tick();
      checks++;
      if (ovld1 !== 1'b1 || dout1 !== lines[k]) begin
        failures++; $display("FAIL b2b_resp k=%0d got=%b/%h exp=1/%h", k, ovld1, dout1, lines[k]);
      end
      tick();
      checks++;
      if (ready1 !== 1'b1 || ovld1 !== 1'b0) begin
        failures++; $display("FAIL b2b_ready k=%0d got=ready%b/valid%b exp=ready1/valid0", k, ready1, ovld1);
      end
    end
    valid1 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    valid0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    valid1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    #2;
    test_reset();
    test_write_read();
    test_busy_block();
    test_combined_alias();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
